// File: rtl/rs232_arb_pkg.sv
// Shared types and constants for the RS232 transmitter arbiter.
// Contents: FSM state enum, counter width, index-width helper, default watchdog length.
package rs232_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_t;

   // Gap and timeout counters are sized for the 65535 parameter ceiling.
   localparam int unsigned CNT_W = 16;

   // Width of an index into n items (never less than one bit).
   function automatic int unsigned id_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Twelve bit-times: start, 8 data, stop, plus margin.
   function automatic int unsigned timeout_cycles(input int unsigned clk_hz, input int unsigned bps);
      return (clk_hz / bps) * 12;
   endfunction

   localparam int unsigned DEFAULT_TIMEOUT = timeout_cycles(50_000_000, 115_200);

endpackage

// File: rtl/rs232_rr_picker.sv
// Combinational rotated priority encoder: first set req bit at or after ptr wins.
// Ports: req (request vector), ptr (search start), any (some request set),
//        gnt (one-hot winner), gnt_id (winner index).
module rs232_rr_picker
   import rs232_arb_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = id_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         any,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_id
);

   // Walk the N slots starting at ptr, wrapping modulo N.
   always_comb begin
      int unsigned slot;
      slot   = 0;
      any    = 1'b0;
      gnt    = '0;
      gnt_id = '0;
      for (int unsigned i = 0; i < N; i++) begin
         slot = 32'(ptr) + i;
         if (slot >= N) begin
            slot = slot - N;
         end
         if (!any && req[W'(slot)]) begin
            any            = 1'b1;
            gnt[W'(slot)]  = 1'b1;
            gnt_id         = W'(slot);
         end
      end
   end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin scheduler sharing one RS232 byte transmitter among P_NUM_REQ requesters.
// Ports: I_Clk/I_Rst_n (clock, async active-low reset); I_Req_Valid/I_Req_Data/O_Req_Ready
//        (per-requester byte handshake, ready is combinational in IDLE);
//        O_Tx_En/O_Tx_Data/I_Tx_Busy (transmitter side); O_Grant_Id (owner of current/last
//        frame); O_Active (not IDLE); O_Timeout/I_Err_Clr (sticky watchdog flag and clear).
module rs232_tx_arbiter
   import rs232_arb_pkg::*;
#(
   parameter int unsigned P_NUM_REQ        = 4,
   parameter int unsigned P_GAP_CYCLES     = 32,
   parameter int unsigned P_TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                         I_Clk,
   input  logic                         I_Rst_n,
   input  logic [P_NUM_REQ-1:0]         I_Req_Valid,
   input  logic [8*P_NUM_REQ-1:0]       I_Req_Data,
   output logic [P_NUM_REQ-1:0]         O_Req_Ready,
   output logic                         O_Tx_En,
   output logic [7:0]                   O_Tx_Data,
   input  logic                         I_Tx_Busy,
   output logic [$clog2(P_NUM_REQ)-1:0] O_Grant_Id,
   output logic                         O_Active,
   output logic                         O_Timeout,
   input  logic                         I_Err_Clr
);

   localparam int unsigned      ID_W     = id_w(P_NUM_REQ);
   localparam logic [CNT_W-1:0] GAP_LAST = (P_GAP_CYCLES == 0) ? '0 : CNT_W'(P_GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(P_TIMEOUT_CYCLES - 1);
   localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(P_NUM_REQ - 1);
   // With no gap configured, a finished frame returns straight to IDLE.
   localparam state_t           AFTER_FRAME = (P_GAP_CYCLES == 0) ? IDLE : GAP;

   state_t                 state;
   logic [ID_W-1:0]        rr_ptr;
   logic [CNT_W-1:0]       to_cnt;
   logic [CNT_W-1:0]       gap_cnt;

   logic                   pick_any;
   logic [P_NUM_REQ-1:0]   pick_gnt;
   logic [ID_W-1:0]        pick_id;
   logic [7:0]             pick_byte;
   logic                   timeout_set;

   rs232_rr_picker #(
      .N (P_NUM_REQ),
      .W (ID_W)
   ) u_picker (
      .req    (I_Req_Valid),
      .ptr    (rr_ptr),
      .any    (pick_any),
      .gnt    (pick_gnt),
      .gnt_id (pick_id)
   );

   // Transfer strobe; gated by reset so no accept is signalled while held in reset.
   assign O_Req_Ready = ((state == IDLE) && pick_any && I_Rst_n) ? pick_gnt : '0;
   assign O_Active    = (state != IDLE);

   // Busy falling in the limit cycle takes precedence over the watchdog.
   assign timeout_set = (state == WAIT_DONE) && I_Tx_Busy && (to_cnt == TO_LAST);

   // One-hot AND-OR mux of the winner's byte.
   always_comb begin
      pick_byte = '0;
      for (int unsigned k = 0; k < P_NUM_REQ; k++) begin
         if (pick_gnt[k]) begin
            pick_byte = pick_byte | I_Req_Data[8*k +: 8];
         end
      end
   end

   // Frame sequencer with registered transmitter-side outputs.
   always_ff @(posedge I_Clk or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         to_cnt     <= '0;
         gap_cnt    <= '0;
         O_Tx_En    <= 1'b0;
         O_Tx_Data  <= 8'h00;
         O_Grant_Id <= '0;
         O_Timeout  <= 1'b0;
      end else begin
         O_Tx_En <= 1'b0;

         if (timeout_set) begin
            O_Timeout <= 1'b1;
         end else if (I_Err_Clr) begin
            O_Timeout <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (pick_any) begin
                  O_Tx_Data  <= pick_byte;
                  O_Grant_Id <= pick_id;
                  rr_ptr     <= (pick_id == ID_MAX) ? '0 : pick_id + ID_W'(1);
                  O_Tx_En    <= 1'b1;
                  state      <= LAUNCH;
               end
            end
            LAUNCH: begin
               to_cnt <= '0;
               state  <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (to_cnt != '1) begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
               gap_cnt <= '0;
               if (!I_Tx_Busy || (to_cnt == TO_LAST)) begin
                  state <= AFTER_FRAME;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Self-checking bench for rs232_tx_arbiter (4 requesters, 32-cycle gap, 5208-cycle watchdog).
module tb_rs232_tx_arbiter;

   localparam int TO_CYC = 5208;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout;
   logic        err_clr;

   // Fake transmitter: auto mode holds busy 3 clocks after the enable, manual mode follows manual_busy.
   logic        auto_tx;
   logic        manual_busy;
   int          busy_cnt = 0;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [7:0]  last_data;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  exp_ready;
      logic [1:0]  exp_id;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs [13];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!auto_tx)           busy_cnt <= 0;
      else if (tx_en)         busy_cnt <= 3;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   assign tx_busy = tx_en | (auto_tx ? (busy_cnt != 0) : manual_busy);

   rs232_tx_arbiter #(
      .P_NUM_REQ        (4),
      .P_GAP_CYCLES     (32),
      .P_TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .I_Clk       (clk),
      .I_Rst_n     (rst_n),
      .I_Req_Valid (req_valid),
      .I_Req_Data  (req_data),
      .O_Req_Ready (req_ready),
      .O_Tx_En     (tx_en),
      .O_Tx_Data   (tx_data),
      .I_Tx_Busy   (tx_busy),
      .O_Grant_Id  (grant_id),
      .O_Active    (active),
      .O_Timeout   (timeout),
      .I_Err_Clr   (err_clr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (active && n < 200) begin
         cyc();
         n++;
      end
      chk("wait_idle", 32'(active), 32'd0);
   endtask

   // One full frame from a table vector: accept, launch, hold, return to IDLE.
   task automatic run_vec(input int idx);
      int   pulses;
      logic stable;
      wait_idle();
      chk($sformatf("v%0d_held_data", idx), 32'(tx_data), 32'(last_data));
      req_valid = vecs[idx].valid;
      req_data  = vecs[idx].data;
      #1;
      chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'(vecs[idx].exp_ready));
      cyc();
      req_valid = '0;
      chk($sformatf("v%0d_tx_en", idx), 32'(tx_en), 32'd1);
      chk($sformatf("v%0d_grant", idx), 32'(grant_id), 32'(vecs[idx].exp_id));
      chk($sformatf("v%0d_data", idx), 32'(tx_data), 32'(vecs[idx].exp_data));
      last_data = vecs[idx].exp_data;
      pulses = 0;
      stable = 1'b1;
      for (int n = 0; n < 100; n++) begin
         cyc();
         if (tx_en) pulses++;
         if (tx_data !== vecs[idx].exp_data) stable = 1'b0;
         if (!active) break;
      end
      chk($sformatf("v%0d_extra_pulses", idx), 32'(pulses), 32'd0);
      chk($sformatf("v%0d_data_stable", idx), 32'(stable), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      int   k;
      logic quiet;

      // Fairness from reset: ptr 0, then 0,1,2,3,0,1,2,3.
      for (int i = 0; i < 8; i++) begin
         vecs[i].valid     = 4'b1111;
         vecs[i].data      = 32'hD3C2B1A0;
         vecs[i].exp_ready = 4'b0001 << (i % 4);
         vecs[i].exp_id    = 2'(i % 4);
         vecs[i].exp_data  = 8'hA0 + 8'(8'h11 * (i % 4));
      end
      // ptr 0 -> single request 2 (ptr 3) -> {1,0} picks 0 (ptr 1) -> {3,0} picks 3 (ptr 0)
      vecs[8]  = '{4'b0100, 32'h00A50000, 4'b0100, 2'd2, 8'hA5};
      vecs[9]  = '{4'b0011, 32'h00001122, 4'b0001, 2'd0, 8'h22};
      vecs[10] = '{4'b1001, 32'h7F000000, 4'b1000, 2'd3, 8'h7F};
      vecs[11] = '{4'b1000, 32'h80000000, 4'b1000, 2'd3, 8'h80};
      vecs[12] = '{4'b0001, 32'h000000FF, 4'b0001, 2'd0, 8'hFF};

      rst_n       = 1'b0;
      req_valid   = 4'b0001;
      req_data    = 32'h000000EE;
      err_clr     = 1'b0;
      auto_tx     = 1'b1;
      manual_busy = 1'b0;
      last_data   = 8'h00;

      // Reset state, with a request already valid.
      #3;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_tx_en", 32'(tx_en), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      cyc();
      cyc();
      req_valid = '0;
      rst_n     = 1'b1;
      cyc();

      for (int i = 0; i < 13; i++) run_vec(i);

      // Gap: busy low during cycle T, pending request gets ready at T+33, enable at T+34.
      auto_tx     = 1'b0;
      manual_busy = 1'b1;
      wait_idle();
      req_valid = 4'b0010;
      req_data  = 32'h00003C00;
      #1;
      chk("gap_first_ready", 32'(req_ready), 32'b0010);
      cyc();
      req_valid = 4'b0001;
      req_data  = 32'h00000011;
      chk("gap_first_tx_en", 32'(tx_en), 32'd1);
      cyc();
      cyc();
      manual_busy = 1'b0;
      quiet = (req_ready == 4'b0000);
      for (int n = 1; n <= 32; n++) begin
         cyc();
         if (req_ready != 4'b0000) quiet = 1'b0;
      end
      chk("gap_quiet", 32'(quiet), 32'd1);
      cyc();
      chk("gap_ready_t33", 32'(req_ready), 32'b0001);
      cyc();
      req_valid = '0;
      chk("gap_tx_en_t34", 32'(tx_en), 32'd1);
      chk("gap_data", 32'(tx_data), 32'h11);
      wait_idle();

      // Watchdog with busy stuck high.
      manual_busy = 1'b1;
      req_valid   = 4'b0100;
      req_data    = 32'h00440000;
      #1;
      cyc();
      req_valid = '0;
      chk("wd_launch", 32'(tx_en), 32'd1);
      k = 0;
      while (!timeout && k < 6000) begin
         cyc();
         k++;
      end
      chk("wd_latency", 32'(k), 32'(TO_CYC + 1));
      chk("wd_active_in_gap", 32'(active), 32'd1);
      req_valid = 4'b0001;
      req_data  = 32'h00000055;
      k = 0;
      while (req_ready == 4'b0000 && k < 60) begin
         cyc();
         k++;
      end
      chk("wd_resume_ready", 32'(req_ready), 32'b0001);
      cyc();
      req_valid = '0;
      chk("wd_resume_tx_en", 32'(tx_en), 32'd1);
      chk("wd_sticky", 32'(timeout), 32'd1);
      manual_busy = 1'b0;
      wait_idle();
      chk("wd_still_sticky", 32'(timeout), 32'd1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("wd_cleared", 32'(timeout), 32'd0);

      // Set and clear together: set wins, the next cycle's clear then takes effect.
      manual_busy = 1'b1;
      req_valid   = 4'b0100;
      #1;
      cyc();
      req_valid = '0;
      err_clr   = 1'b1;
      k = 0;
      while (!timeout && k < 6000) begin
         cyc();
         k++;
      end
      chk("wd_set_wins", 32'(k), 32'(TO_CYC + 1));
      cyc();
      chk("wd_clear_after", 32'(timeout), 32'd0);
      err_clr     = 1'b0;
      manual_busy = 1'b0;
      wait_idle();

      // Mid-frame asynchronous reset.
      manual_busy = 1'b1;
      req_valid   = 4'b0100;
      req_data    = 32'h00C30000;
      #1;
      cyc();
      req_valid = '0;
      cyc();
      cyc();
      req_valid = 4'b0110;
      req_data  = 32'h00005A00;
      chk("mr_pre_active", 32'(active), 32'd1);
      chk("mr_pre_data", 32'(tx_data), 32'hC3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_active", 32'(active), 32'd0);
      chk("mr_tx_data", 32'(tx_data), 32'd0);
      chk("mr_grant", 32'(grant_id), 32'd0);
      chk("mr_tx_en", 32'(tx_en), 32'd0);
      chk("mr_ready", 32'(req_ready), 32'd0);
      cyc();
      cyc();
      chk("mr_ready_held", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("mr_first_ready", 32'(req_ready), 32'b0010);
      cyc();
      req_valid = '0;
      chk("mr_first_tx_en", 32'(tx_en), 32'd1);
      chk("mr_first_grant", 32'(grant_id), 32'd1);
      chk("mr_first_data", 32'(tx_data), 32'h5A);
      manual_busy = 1'b0;
      wait_idle();

      // Skipped requester: ptr 2 -> grant 3 (ptr 0) -> grant 0 (ptr 1), then 1 drops out.
      auto_tx   = 1'b1;
      req_valid = 4'b1000;
      req_data  = 32'h66000000;
      #1;
      cyc();
      req_valid = '0;
      chk("sk_grant3", 32'(grant_id), 32'd3);
      wait_idle();
      req_valid = 4'b0111;
      req_data  = 32'h00332211;
      #1;
      chk("sk_ready0", 32'(req_ready), 32'b0001);
      cyc();
      req_valid = 4'b0100;
      chk("sk_grant0", 32'(grant_id), 32'd0);
      k = 0;
      while (req_ready == 4'b0000 && k < 100) begin
         cyc();
         k++;
      end
      chk("sk_next_ready", 32'(req_ready), 32'b0100);
      cyc();
      req_valid = '0;
      chk("sk_next_grant", 32'(grant_id), 32'd2);
      chk("sk_next_data", 32'(tx_data), 32'h33);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Round-robin scheduler sharing one RS232 byte transmitter among `P_NUM_REQ` requesters. Each requester offers a byte on a valid/ready handshake. The block grants one requester per frame, drives the transmitter's rising-edge enable and data inputs, and waits for the transmitter's busy flag to clear. It then enforces an inter-frame gap and grants the next requester. A watchdog flags a transmitter that never releases busy.

## Interface
Parameters:
- `P_NUM_REQ`, 4: number of requesters, 2..8.
- `P_GAP_CYCLES`, 32: idle clocks inserted after busy falls, 0..65535. Covers the final 1/16 stop bit the transmitter does not hold busy for.
- `P_TIMEOUT_CYCLES`, 5208: max clocks spent in WAIT_DONE, equal to 12 bit-times at 50 MHz / 115200. Must be ≥ 2.

Ports:
- `I_Clk`  in  1  sole clock.
- `I_Rst_n`  in  1  asynchronous, active-low reset.
- `I_Req_Valid`  in  `P_NUM_REQ`  per-requester byte valid.
- `I_Req_Data`  in  `8*P_NUM_REQ`  requester k byte on bits `[8k+7:8k]`.
- `O_Req_Ready`  out  `P_NUM_REQ`  one-hot, single-cycle accept strobe.
- `O_Tx_En`  out  1  transmitter enable, a one-cycle pulse per frame.
- `O_Tx_Data`  out  8  byte to the transmitter.
- `I_Tx_Busy`  in  1  transmitter busy, which includes its own combinational OR of enable.
- `O_Grant_Id`  out  `$clog2(P_NUM_REQ)`  index of the requester owning the current or last frame.
- `O_Active`  out  1  high in every state except IDLE.
- `O_Timeout`  out  1  sticky watchdog error.
- `I_Err_Clr`  in  1  clears `O_Timeout`.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- **IDLE**
  - If any `I_Req_Valid` is set, pick the winner by round-robin, starting the search at `rr_ptr`.
  - In the same cycle, combinationally assert `O_Req_Ready[winner]`; this is the transfer cycle.
  - Register the winner's byte into `O_Tx_Data` and the winner's index into `O_Grant_Id`.
  - Set `rr_ptr <= winner+1`, wrapping to 0 at `P_NUM_REQ`. Go to LAUNCH.
  - With no valid requester, stay in IDLE.
- **LAUNCH**
  - `O_Tx_En=1` for exactly this cycle. Clear the timeout counter. Go to WAIT_DONE.
- **WAIT_DONE**
  - `O_Tx_En=0`. Increment the timeout counter every cycle.
  - If `I_Tx_Busy==0`, go to GAP; if `P_GAP_CYCLES==0`, go directly to IDLE.
  - Otherwise, when the counter reaches `P_TIMEOUT_CYCLES-1`, set `O_Timeout` and go to GAP.
  - If busy falls in the same cycle the counter reaches the limit, busy takes precedence and no error is raised.
- **GAP**
  - Count `P_GAP_CYCLES` clocks, then go to IDLE.
- `O_Tx_Data` is held from acceptance until the next acceptance. The transmitter samples data two clocks after the enable edge, so the byte must not change mid-frame.
- `O_Req_Ready` is zero outside the IDLE transfer cycle. A requester that drops valid before it is granted is simply skipped; there is no penalty.
- `O_Timeout`:
  - Set by the watchdog; cleared by `I_Err_Clr`.
  - If set and clear occur in the same cycle, set wins.
  - A timeout does not stall arbitration.
- Reset, asynchronous and asserted at any time:
  - State returns to IDLE, `rr_ptr=0`, and all counters clear.
  - `O_Req_Ready=0`, `O_Tx_En=0`, `O_Tx_Data=8'h00`, `O_Grant_Id=0`, `O_Active=0`, `O_Timeout=0`.
  - A frame in flight is abandoned; the transmitter's own reset covers its line state.

## Timing
- Latency from valid (in IDLE) to ready: 0 cycles, combinational in IDLE.
- From ready to `O_Tx_En`: 1 cycle.
- `O_Tx_En` stays low for ≥ 2 cycles between pulses, which the transmitter's edge detector requires. This is guaranteed by WAIT_DONE plus IDLE.
- Minimum frame spacing, from one enable pulse to the next: busy duration + `P_GAP_CYCLES` + 2 clocks.
- Arbitration is fair: with all N requesters continuously valid, grants follow `rr_ptr`, `rr_ptr+1`, …, covering every requester once per N frames.
- Counter widths are `$clog2` of the parameter ceiling. The timeout counter is 16 bits, and it saturates rather than wrapping.

## Structure
- Package `rs232_arb_pkg`:
  - state enum `{IDLE, LAUNCH, WAIT_DONE, GAP}`, 2 bits;
  - `$clog2`-based width constant helper;
  - default-timeout formula `(CLK/BPS)*12`.
- Sub-module `rs232_rr_picker`: purely combinational.
  - Inputs: `req[N-1:0]` and `ptr`.
  - Outputs: `any`, one-hot `gnt`, and `gnt_id`.
  - Implemented as a rotated priority encoder. It is instantiated once.

## Test plan
- **Single request.** Reset, then pulse `I_Req_Valid[2]` with data 8'hA5.
  - Expected: `O_Req_Ready=4'b0100` in the same cycle.
  - `O_Tx_En` high for exactly 1 cycle, on the next clock.
  - `O_Tx_Data=8'hA5` held until the next acceptance; `O_Grant_Id=2`.
- **Round-robin fairness.** Hold all 4 valid with distinct bytes for 8 frames.
  - Expected grant order: 0,1,2,3,0,1,2,3.
  - Exactly one `O_Tx_En` pulse per frame.
- **Gap enforcement.** With `P_GAP_CYCLES=32`, drop busy at cycle T while a request is pending.
  - Expected: the next `O_Req_Ready` occurs at T+33 and `O_Tx_En` at T+34.
- **Watchdog.** Hold `I_Tx_Busy=1` forever.
  - Expected: `O_Timeout` rises `P_TIMEOUT_CYCLES` clocks after LAUNCH, and arbitration resumes.
  - Pulse `I_Err_Clr` and check it clears; assert set and clear together and check set wins.
- **Mid-frame reset.** Assert `I_Rst_n=0` during WAIT_DONE.
  - Expected: all outputs go to their reset values immediately, without waiting for a clock.
  - After release, the first grant goes to the lowest-index valid requester.
- **Skipped requester.** Drop valid on requester 1 while requester 0 is transmitting.
  - Expected: no ready pulse to requester 1; the next grant goes to requester 2.
